prog_loader: RTL

PROG_LOADER -- requirements
Module: prog_loader

---
 rtl/prog_loader.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/prog_loader.sv
// Purpose : streams a length-prefixed program image from the flash reader into program RAM, holding the CPU in reset meanwhile.
// Latency : one cycle from an accepted DATA byte to its mem_we/mem_addr/mem_wdata write strobe.
// Backpressure: byte_ready is high only in LEN/DATA/CSUM; a low byte_valid stalls the FSM with no change. Option macro: LOADER_CSUM_EN.
module prog_loader #(
    parameter logic [7:0] BASE_ADDR = 8'h00
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] byte_in,
    input  logic       byte_valid,
    output logic       byte_ready,
    output logic       mem_we,
    output logic [7:0] mem_addr,
    output logic [7:0] mem_wdata,
    output logic       cpu_hold,
    output logic       load_done,
    output logic       load_err
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LEN  = 3'd1,
        DATA = 3'd2,
        CSUM = 3'd3,
        DONE = 3'd4,
        ERR  = 3'd5
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic [7:0] cur_addr;
    // 9 bits so that a length byte of 0 can stand for 256 data bytes
    logic [8:0] remaining;
    logic       accept;
    logic       last_data;
`ifdef LOADER_CSUM_EN
    logic [7:0] run_sum;
    logic       load_err_r;
`endif

    assign accept    = byte_valid && byte_ready;
    assign last_data = (remaining == 9'd1);

`ifdef LOADER_CSUM_EN
    assign load_err = load_err_r;
`else
    // without checksum checking a load can never fail
    assign load_err = 1'b0;
`endif

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // next-state and handshake decode
    always_comb begin
        state_nxt  = state;
        byte_ready = 1'b0;
        case (state)
            IDLE, DONE, ERR: begin
                if (start) begin
                    state_nxt = LEN;
                end
            end
            LEN: begin
                byte_ready = 1'b1;
                if (accept) begin
                    state_nxt = DATA;
                end
            end
            DATA: begin
                byte_ready = 1'b1;
                if (accept && last_data) begin
`ifdef LOADER_CSUM_EN
                    state_nxt = CSUM;
`else
                    state_nxt = DONE;
`endif
                end
            end
            CSUM: begin
                byte_ready = 1'b1;
`ifdef LOADER_CSUM_EN
                if (accept) begin
                    state_nxt = (byte_in == run_sum) ? DONE : ERR;
                end
`endif
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // datapath: address/count/sum bookkeeping, write strobe and status flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_we     <= 1'b0;
            mem_addr   <= 8'h00;
            mem_wdata  <= 8'h00;
            cpu_hold   <= 1'b0;
            load_done  <= 1'b0;
            cur_addr   <= 8'h00;
            remaining  <= 9'd0;
`ifdef LOADER_CSUM_EN
            run_sum    <= 8'h00;
            load_err_r <= 1'b0;
`endif
        end else begin
            // write strobe is a single-cycle pulse per accepted DATA byte
            mem_we <= 1'b0;
            case (state)
                IDLE, DONE, ERR: begin
                    if (start) begin
                        cpu_hold   <= 1'b1;
                        load_done  <= 1'b0;
                        cur_addr   <= BASE_ADDR;
`ifdef LOADER_CSUM_EN
                        run_sum    <= 8'h00;
                        load_err_r <= 1'b0;
`endif
                    end
                end
                LEN: begin
                    if (accept) begin
                        remaining <= {(byte_in == 8'h00), byte_in};
                    end
                end
                DATA: begin
                    if (accept) begin
                        mem_we    <= 1'b1;
                        mem_addr  <= cur_addr;
                        mem_wdata <= byte_in;
                        // natural 8-bit overflow gives the FF -> 00 wrap
                        cur_addr  <= cur_addr + 8'd1;
                        remaining <= remaining - 9'd1;
`ifdef LOADER_CSUM_EN
                        run_sum   <= run_sum + byte_in;
`else
                        if (last_data) begin
                            load_done <= 1'b1;
                            cpu_hold  <= 1'b0;
                        end
`endif
                    end
                end
                CSUM: begin
`ifdef LOADER_CSUM_EN
                    if (accept) begin
                        if (byte_in == run_sum) begin
                            load_done <= 1'b1;
                            cpu_hold  <= 1'b0;
                        end else begin
                            // CPU stays held so a corrupt image never runs
                            load_err_r <= 1'b1;
                        end
                    end
`endif
                end
                default: begin
                end
            endcase
        end
    end

endmodule
